// File: rtl/tlb_rqst_arbiter.sv
// tlb_rqst_arbiter
//   Shares a single speculative-TLB translation port between NUM_REQ
//   requesters. A round-robin grant picks one pending request in IDLE, the
//   FSM strobes the TLB for one cycle (ISSUE), waits for DONE_TRANS or the
//   watchdog (WAIT), then returns the result to the owning requester for one
//   cycle (RESP).
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   REQ_VALID/SPEC     per-requester request valid / speculative flag
//   REQ_VADDR          packed per-requester virtual addresses
//   REQ_READY          one-hot accept, combinational, only in IDLE
//   RSP_*              one-hot response strobe plus result, one cycle
//   TRANS_RQST,
//   SPEC_TLB_RQST,
//   VIRT_ADDR_LOOKUP   request side of the TLB port
//   DONE_TRANS,
//   PHY_ADDR_TRANS,
//   TLB_HIT, SPEC_HIT  result side of the TLB port
//   BUSY               high whenever the FSM is not in IDLE
module tlb_rqst_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        REQ_VALID,
    input  logic [NUM_REQ-1:0]        REQ_SPEC,
    input  logic [NUM_REQ*ADDR_W-1:0] REQ_VADDR,
    output logic [NUM_REQ-1:0]        REQ_READY,
    output logic [NUM_REQ-1:0]        RSP_VALID,
    output logic [ADDR_W-1:0]         RSP_PADDR,
    output logic                      RSP_TLB_HIT,
    output logic                      RSP_SPEC_HIT,
    output logic                      RSP_ERR,
    output logic                      TRANS_RQST,
    output logic                      SPEC_TLB_RQST,
    output logic [ADDR_W-1:0]         VIRT_ADDR_LOOKUP,
    input  logic                      DONE_TRANS,
    input  logic [ADDR_W-1:0]         PHY_ADDR_TRANS,
    input  logic                      TLB_HIT,
    input  logic                      SPEC_HIT,
    output logic                      BUSY
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;

    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W:0]     sum;
    logic [IDX_W-1:0]   cand;
    logic [NUM_REQ-1:0] idx_oh;

    // Cyclic search from rr_ptr. Walking offsets from the far end down to 0
    // lets the closest valid requester overwrite any farther one.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        sum       = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(NUM_REQ))
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            cand = sum[IDX_W-1:0];
            if (REQ_VALID[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        REQ_READY = '0;
        idx_oh    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            REQ_READY[i] = (state == IDLE) && grant_vld && (grant_idx == IDX_W'(i));
            idx_oh[i]    = (idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            idx              <= '0;
            cnt              <= '0;
            RSP_VALID        <= '0;
            RSP_PADDR        <= '0;
            RSP_TLB_HIT      <= 1'b0;
            RSP_SPEC_HIT     <= 1'b0;
            RSP_ERR          <= 1'b0;
            TRANS_RQST       <= 1'b0;
            SPEC_TLB_RQST    <= 1'b0;
            VIRT_ADDR_LOOKUP <= '0;
            BUSY             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // READY exists exactly when grant_vld, so this is VALID&READY.
                    if (grant_vld) begin
                        idx              <= grant_idx;
                        VIRT_ADDR_LOOKUP <= REQ_VADDR[int'(grant_idx)*ADDR_W +: ADDR_W];
                        TRANS_RQST       <= 1'b1;
                        SPEC_TLB_RQST    <= REQ_SPEC[grant_idx];
                        BUSY             <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    TRANS_RQST    <= 1'b0;
                    SPEC_TLB_RQST <= 1'b0;
                    cnt           <= '0;
                    state         <= WAIT;
                end
                WAIT: begin
                    // DONE is tested first so it wins over a same-cycle timeout.
                    if (DONE_TRANS) begin
                        RSP_VALID    <= idx_oh;
                        RSP_PADDR    <= PHY_ADDR_TRANS;
                        RSP_TLB_HIT  <= TLB_HIT;
                        RSP_SPEC_HIT <= SPEC_HIT;
                        RSP_ERR      <= 1'b0;
                        state        <= RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        RSP_VALID    <= idx_oh;
                        RSP_PADDR    <= '0;
                        RSP_TLB_HIT  <= 1'b0;
                        RSP_SPEC_HIT <= 1'b0;
                        RSP_ERR      <= 1'b1;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    RSP_VALID        <= '0;
                    RSP_PADDR        <= '0;
                    RSP_TLB_HIT      <= 1'b0;
                    RSP_SPEC_HIT     <= 1'b0;
                    RSP_ERR          <= 1'b0;
                    VIRT_ADDR_LOOKUP <= '0;
                    BUSY             <= 1'b0;
                    rr_ptr           <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_rqst_arbiter.sv
module tb_tlb_rqst_arbiter;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req_valid;
    logic [3:0]      req_spec;
    logic [3:0][8:0] va;
    logic [35:0]     req_vaddr;
    logic [3:0]      req_ready;
    logic [3:0]      rsp_valid;
    logic [8:0]      rsp_paddr;
    logic            rsp_tlb_hit, rsp_spec_hit, rsp_err;
    logic            trans_rqst, spec_tlb_rqst;
    logic [8:0]      virt_addr_lookup;
    logic            done_trans;
    logic [8:0]      phy_addr_trans;
    logic            tlb_hit, spec_hit;
    logic            busy;

    int total = 0;
    int bad   = 0;

    assign req_vaddr = va;

    always #5 clk = ~clk;

    tlb_rqst_arbiter #(.NUM_REQ(4), .ADDR_W(9), .TIMEOUT(64)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .REQ_VALID        (req_valid),
        .REQ_SPEC         (req_spec),
        .REQ_VADDR        (req_vaddr),
        .REQ_READY        (req_ready),
        .RSP_VALID        (rsp_valid),
        .RSP_PADDR        (rsp_paddr),
        .RSP_TLB_HIT      (rsp_tlb_hit),
        .RSP_SPEC_HIT     (rsp_spec_hit),
        .RSP_ERR          (rsp_err),
        .TRANS_RQST       (trans_rqst),
        .SPEC_TLB_RQST    (spec_tlb_rqst),
        .VIRT_ADDR_LOOKUP (virt_addr_lookup),
        .DONE_TRANS       (done_trans),
        .PHY_ADDR_TRANS   (phy_addr_trans),
        .TLB_HIT          (tlb_hit),
        .SPEC_HIT         (spec_hit),
        .BUSY             (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs changed after this are seen by the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, ".rsp_paddr"}, 32'(rsp_paddr), 0);
        check({tag, ".rsp_flags"}, {29'd0, rsp_tlb_hit, rsp_spec_hit, rsp_err}, 0);
        check({tag, ".strobes"}, {30'd0, trans_rqst, spec_tlb_rqst}, 0);
        check({tag, ".vaddr"}, 32'(virt_addr_lookup), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".ready"}, 32'(req_ready), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_spec = '0; va = '0;
        done_trans = 1'b0; phy_addr_trans = '0; tlb_hit = 1'b0; spec_hit = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // ---- single request with speculative flag
        req_valid = 4'b0001; req_spec = 4'b0001; va[0] = 9'h0A5;
        #1 check("single.ready", 32'(req_ready), 32'h1);
        tick();
        check("single.trans", 32'(trans_rqst), 1);
        check("single.spec", 32'(spec_tlb_rqst), 1);
        check("single.vaddr", 32'(virt_addr_lookup), 32'h0A5);
        check("single.busy", 32'(busy), 1);
        check("single.ready_busy", 32'(req_ready), 0);
        req_valid = '0; req_spec = '0;
        tick();
        check("single.wait_strobes", {30'd0, trans_rqst, spec_tlb_rqst}, 0);
        check("single.wait_vaddr", 32'(virt_addr_lookup), 32'h0A5);
        tick(); tick();
        done_trans = 1'b1; phy_addr_trans = 9'h1C3; tlb_hit = 1'b1;
        tick();
        done_trans = 1'b0; phy_addr_trans = '0; tlb_hit = 1'b0;
        check("single.rsp_valid", 32'(rsp_valid), 32'h1);
        check("single.rsp_paddr", 32'(rsp_paddr), 32'h1C3);
        check("single.rsp_tlb_hit", 32'(rsp_tlb_hit), 1);
        check("single.rsp_spec_hit", 32'(rsp_spec_hit), 0);
        check("single.rsp_err", 32'(rsp_err), 0);
        tick();
        check_all_zero("single.after");

        // ---- round robin from a fresh pointer
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        for (int i = 0; i < 4; i++) va[i] = 9'(9'h100 + i * 9'h011);
        req_valid = 4'b1111;
        #1;
        for (int n = 0; n < 5; n++) begin
            int g;
            g = n % 4;
            check($sformatf("rr%0d.ready", n), 32'(req_ready), 32'(1) << g);
            tick();
            check($sformatf("rr%0d.trans", n), 32'(trans_rqst), 1);
            check($sformatf("rr%0d.vaddr", n), 32'(virt_addr_lookup), 32'(va[g]));
            tick();
            done_trans = 1'b1; phy_addr_trans = 9'(9'h040 + g);
            tick();
            done_trans = 1'b0;
            check($sformatf("rr%0d.rsp_valid", n), 32'(rsp_valid), 32'(1) << g);
            check($sformatf("rr%0d.rsp_paddr", n), 32'(rsp_paddr), 32'(9'h040 + g));
            tick();
        end
        req_valid = '0;
        tick();   // rr_ptr now 1

        // ---- timeout from requester 2
        req_valid = 4'b0100; va[2] = 9'h1F0;
        #1 check("to.ready", 32'(req_ready), 32'h4);
        tick();   // ISSUE
        req_valid = '0;
        tlb_hit = 1'b1;   // must not leak into an error response
        tick();   // WAIT cycle 1
        for (int c = 0; c < 63; c++) tick();
        check("to.wait64_rsp", 32'(rsp_valid), 0);
        check("to.wait64_busy", 32'(busy), 1);
        tick();
        tlb_hit = 1'b0;
        check("to.rsp_valid", 32'(rsp_valid), 32'h4);
        check("to.rsp_err", 32'(rsp_err), 1);
        check("to.rsp_paddr", 32'(rsp_paddr), 0);
        check("to.rsp_tlb_hit", 32'(rsp_tlb_hit), 0);
        tick();   // rr_ptr now 3

        // ---- DONE on the final timeout cycle
        req_valid = 4'b0010; va[1] = 9'h133;
        #1 check("late.ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        for (int c = 0; c < 63; c++) tick();
        done_trans = 1'b1; phy_addr_trans = 9'h077; tlb_hit = 1'b1; spec_hit = 1'b1;
        tick();
        done_trans = 1'b0; phy_addr_trans = '0; tlb_hit = 1'b0; spec_hit = 1'b0;
        check("late.rsp_valid", 32'(rsp_valid), 32'h2);
        check("late.rsp_err", 32'(rsp_err), 0);
        check("late.rsp_paddr", 32'(rsp_paddr), 32'h077);
        check("late.hits", {30'd0, rsp_tlb_hit, rsp_spec_hit}, 3);
        tick();   // rr_ptr now 2

        // ---- stray DONE in IDLE
        done_trans = 1'b1; phy_addr_trans = 9'h1FF;
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("stray%0d.rsp", c), 32'(rsp_valid), 0);
            check($sformatf("stray%0d.busy", c), 32'(busy), 0);
        end
        done_trans = 1'b0; phy_addr_trans = '0;

        // ---- reset in the middle of WAIT
        req_valid = 4'b0001; va[0] = 9'h0C4;
        tick();   // ISSUE
        req_valid = '0;
        tick(); tick();   // WAIT cycle 2
        rst_n = 1'b0;
        #1 check_all_zero("rstmid");
        tick();
        check("rstmid.c1_rsp", 32'(rsp_valid), 0);
        tick();
        check("rstmid.c2_rsp", 32'(rsp_valid), 0);
        rst_n = 1'b1;
        req_valid = 4'b1000; va[3] = 9'h0E1;
        #1 check("rstmid.ready3", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        check("rstmid.vaddr3", 32'(virt_addr_lookup), 32'h0E1);
        tick();
        done_trans = 1'b1; phy_addr_trans = 9'h0AA;
        tick();
        done_trans = 1'b0;
        check("rstmid.rsp3", 32'(rsp_valid), 32'h8);
        check("rstmid.paddr3", 32'(rsp_paddr), 32'h0AA);
        tick();   // rr_ptr now 0

        // ---- requester 1 withdraws while busy with requester 0
        req_valid = 4'b0001; va[0] = 9'h011; va[1] = 9'h022;
        #1 check("wd.ready0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0010;
        #1 check("wd.ready_busy", 32'(req_ready), 0);
        tick();
        done_trans = 1'b1; phy_addr_trans = 9'h055;
        tick();
        done_trans = 1'b0; req_valid = '0;
        check("wd.rsp0", 32'(rsp_valid), 32'h1);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("wd%0d.rsp", c), 32'(rsp_valid), 0);
            check($sformatf("wd%0d.busy", c), 32'(busy), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
